// File: rtl/mc_control_fsm.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mc_control_fsm : multi-cycle RV32I control sequencer (fetch/decode/exec/wb)
// rev 1.0
// -----------------------------------------------------------------------------
module mc_control_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 EQ,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [2:0]           ALUctrl,
  output logic                 RegWrite,
  output logic                 Illegal,
  output logic [CNT_WIDTH-1:0] InstRet
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] c_OP_LW   = 7'b0000011;
  localparam logic [6:0] c_OP_SW   = 7'b0100011;
  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_I    = 7'b0010011;
  localparam logic [6:0] c_OP_BR   = 7'b1100011;
  localparam logic [6:0] c_OP_JAL  = 7'b1101111;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic                 illegal_q, illegal_d;
  logic                 retire;

  // Subtract only for R-type funct3=000 with funct7b5 set; I-type always adds.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_ok);
    logic [2:0] ctrl;
    ctrl = 3'b000;
    case (f3)
      3'b000:  ctrl = sub_ok ? 3'b001 : 3'b000;
      3'b100:  ctrl = 3'b100;
      3'b110:  ctrl = 3'b011;
      3'b111:  ctrl = 3'b010;
      3'b010:  ctrl = 3'b101;
      3'b001:  ctrl = 3'b110;
      3'b101:  ctrl = 3'b111;
      default: ctrl = 3'b000;
    endcase
    return ctrl;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ImmSrc    = 2'b00;
    ALUctrl   = 3'b000;
    RegWrite  = 1'b0;
    retire    = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
        case (op)
          c_OP_LW, c_OP_SW: state_d = S_MEMADR;
          c_OP_R:           state_d = S_EXECR;
          c_OP_I:           state_d = S_EXECI;
          c_OP_BR:          state_d = S_BRANCH;
          c_OP_JAL:         state_d = S_JAL;
          default:          state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        // op[5] separates sw (0100011) from lw (0000011)
        ImmSrc  = op[5] ? 2'b01 : 2'b00;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUctrl = alu_decode(funct3, funct7b5);
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUctrl = alu_decode(funct3, 1'b0);
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUctrl = 3'b001;
        case (funct3)
          3'b000:  PCWrite = EQ;
          3'b001:  PCWrite = ~EQ;
          default: PCWrite = 1'b0;
        endcase
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase

    // Reset overrides everything so no write escapes while it is held.
    if (rst) begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ImmSrc    = 2'b00;
      ALUctrl   = 3'b000;
      RegWrite  = 1'b0;
    end
  end

  always_comb begin
    instret_d = instret_q + {{(CNT_WIDTH-1){1'b0}}, retire};
    illegal_d = illegal_q | (state_q == S_ILLEGAL);
  end

  assign Illegal = illegal_q;
  assign InstRet = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_mc_control_fsm : cycle-by-cycle vector bench for mc_control_fsm
// rev 1.0
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

  typedef struct packed {
    logic        pcw;
    logic        adr;
    logic        mw;
    logic        irw;
    logic [1:0]  rs;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [1:0]  imm;
    logic [2:0]  alu;
    logic        rw;
    logic        ill;
    logic [31:0] cnt;
  } out_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       eq;
    logic       mr;
    out_t       e;
  } vec_t;

  localparam logic [6:0] c_LW  = 7'b0000011;
  localparam logic [6:0] c_SW  = 7'b0100011;
  localparam logic [6:0] c_R   = 7'b0110011;
  localparam logic [6:0] c_I   = 7'b0010011;
  localparam logic [6:0] c_BR  = 7'b1100011;
  localparam logic [6:0] c_JAL = 7'b1101111;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, EQ, MemReady;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUctrl;
  logic [31:0] InstRet;

  int   n_total = 0;
  int   n_bad   = 0;
  out_t exp_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  mc_control_fsm #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .EQ(EQ), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUctrl(ALUctrl),
    .RegWrite(RegWrite), .Illegal(Illegal), .InstRet(InstRet)
  );

  function automatic out_t o(input logic pcw, adr, mw, irw, input logic [1:0] rs, sa, sb, imm,
                             input logic [2:0] alu, input logic rw, ill, input int c);
    out_t r;
    r = '{pcw: pcw, adr: adr, mw: mw, irw: irw, rs: rs, sa: sa, sb: sb, imm: imm,
          alu: alu, rw: rw, ill: ill, cnt: c};
    return r;
  endfunction

  function automatic vec_t v(input logic r, input logic [6:0] opc, input logic [2:0] f3,
                             input logic f7, eq, mr, input out_t e);
    vec_t x;
    x.rst = r; x.op = opc; x.f3 = f3; x.f7 = f7; x.eq = eq; x.mr = mr; x.e = e;
    return x;
  endfunction

  // Expected-output shorthands for the fixed-output states
  function automatic out_t e_zero(input logic ill, input int c);
    return o(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 0, ill, c);
  endfunction
  function automatic out_t e_fetch(input logic mr, input int c);
    return o(mr, 0, 0, mr, 2'd2, 2'd0, 2'd2, 2'd0, 3'd0, 0, 0, c);
  endfunction
  function automatic out_t e_decode(input int c);
    return o(0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 2'd2, 3'd0, 0, 0, c);
  endfunction
  function automatic out_t e_aluwb(input int c);
    return o(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1, 0, c);
  endfunction

  task automatic apply(input vec_t x, input string tag, input int idx);
    out_t act, want;
    rst = x.rst; op = x.op; funct3 = x.f3; funct7b5 = x.f7; EQ = x.eq; MemReady = x.mr;
    exp_q.push_back(x.e);
    @(negedge clk);
    act  = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
            ALUctrl, RegWrite, Illegal, InstRet};
    want = exp_q.pop_front();
    n_total++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s[%0d] got=%h want=%h", tag, idx, act, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; EQ = 1'b0; MemReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    vecs.push_back(v(1, 7'd0, 3'd0, 0, 0, 1, e_zero(0, 0)));
    // addi (funct7b5 set must not turn it into sub)
    vecs.push_back(v(0, c_I, 3'b000, 1, 0, 1, e_fetch(1, 0)));
    vecs.push_back(v(0, c_I, 3'b000, 1, 0, 1, e_decode(0)));
    vecs.push_back(v(0, c_I, 3'b000, 1, 0, 1, o(0,0,0,0,2'd0,2'd2,2'd1,2'd0,3'b000,0,0,0)));
    vecs.push_back(v(0, c_I, 3'b000, 1, 0, 1, e_aluwb(0)));
    // sub, with one fetch stall
    vecs.push_back(v(0, c_R, 3'b000, 1, 0, 0, e_fetch(0, 1)));
    vecs.push_back(v(0, c_R, 3'b000, 1, 0, 1, e_fetch(1, 1)));
    vecs.push_back(v(0, c_R, 3'b000, 1, 0, 1, e_decode(1)));
    vecs.push_back(v(0, c_R, 3'b000, 1, 0, 1, o(0,0,0,0,2'd0,2'd2,2'd0,2'd0,3'b001,0,0,1)));
    vecs.push_back(v(0, c_R, 3'b000, 1, 0, 1, e_aluwb(1)));
    // add
    vecs.push_back(v(0, c_R, 3'b000, 0, 0, 1, e_fetch(1, 2)));
    vecs.push_back(v(0, c_R, 3'b000, 0, 0, 1, e_decode(2)));
    vecs.push_back(v(0, c_R, 3'b000, 0, 0, 1, o(0,0,0,0,2'd0,2'd2,2'd0,2'd0,3'b000,0,0,2)));
    vecs.push_back(v(0, c_R, 3'b000, 0, 0, 1, e_aluwb(2)));
    // srli -> srl
    vecs.push_back(v(0, c_I, 3'b101, 0, 0, 1, e_fetch(1, 3)));
    vecs.push_back(v(0, c_I, 3'b101, 0, 0, 1, e_decode(3)));
    vecs.push_back(v(0, c_I, 3'b101, 0, 0, 1, o(0,0,0,0,2'd0,2'd2,2'd1,2'd0,3'b111,0,0,3)));
    vecs.push_back(v(0, c_I, 3'b101, 0, 0, 1, e_aluwb(3)));
    // beq taken
    vecs.push_back(v(0, c_BR, 3'b000, 0, 1, 1, e_fetch(1, 4)));
    vecs.push_back(v(0, c_BR, 3'b000, 0, 1, 1, e_decode(4)));
    vecs.push_back(v(0, c_BR, 3'b000, 0, 1, 1, o(1,0,0,0,2'd0,2'd2,2'd0,2'd0,3'b001,0,0,4)));
    // bne with EQ=1, not taken
    vecs.push_back(v(0, c_BR, 3'b001, 0, 1, 1, e_fetch(1, 5)));
    vecs.push_back(v(0, c_BR, 3'b001, 0, 1, 1, e_decode(5)));
    vecs.push_back(v(0, c_BR, 3'b001, 0, 1, 1, o(0,0,0,0,2'd0,2'd2,2'd0,2'd0,3'b001,0,0,5)));
    // lw with three MEMREAD stalls
    vecs.push_back(v(0, c_LW, 3'b010, 0, 0, 1, e_fetch(1, 6)));
    vecs.push_back(v(0, c_LW, 3'b010, 0, 0, 1, e_decode(6)));
    vecs.push_back(v(0, c_LW, 3'b010, 0, 0, 1, o(0,0,0,0,2'd0,2'd2,2'd1,2'd0,3'b000,0,0,6)));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, c_LW, 3'b010, 0, 0, 0, o(0,1,0,0,2'd0,2'd0,2'd0,2'd0,3'b000,0,0,6)));
    vecs.push_back(v(0, c_LW, 3'b010, 0, 0, 1, o(0,1,0,0,2'd0,2'd0,2'd0,2'd0,3'b000,0,0,6)));
    vecs.push_back(v(0, c_LW, 3'b010, 0, 0, 1, o(0,0,0,0,2'd1,2'd0,2'd0,2'd0,3'b000,1,0,6)));
    // sw with one MEMWRITE stall
    vecs.push_back(v(0, c_SW, 3'b010, 0, 0, 1, e_fetch(1, 7)));
    vecs.push_back(v(0, c_SW, 3'b010, 0, 0, 1, e_decode(7)));
    vecs.push_back(v(0, c_SW, 3'b010, 0, 0, 1, o(0,0,0,0,2'd0,2'd2,2'd1,2'd1,3'b000,0,0,7)));
    vecs.push_back(v(0, c_SW, 3'b010, 0, 0, 0, o(0,1,1,0,2'd0,2'd0,2'd0,2'd0,3'b000,0,0,7)));
    vecs.push_back(v(0, c_SW, 3'b010, 0, 0, 1, o(0,1,1,0,2'd0,2'd0,2'd0,2'd0,3'b000,0,0,7)));
    // jal retires once, in ALUWB
    vecs.push_back(v(0, c_JAL, 3'b000, 0, 0, 1, e_fetch(1, 8)));
    vecs.push_back(v(0, c_JAL, 3'b000, 0, 0, 1, e_decode(8)));
    vecs.push_back(v(0, c_JAL, 3'b000, 0, 0, 1, o(1,0,0,0,2'd0,2'd1,2'd2,2'd0,3'b000,0,0,8)));
    vecs.push_back(v(0, c_JAL, 3'b000, 0, 0, 1, e_aluwb(8)));
    vecs.push_back(v(0, c_JAL, 3'b000, 0, 0, 0, e_fetch(0, 9)));

    foreach (vecs[i]) apply(vecs[i], "vec", i);

    // Reset in MEMWRITE with MemReady high: no write, no retire
    apply(v(0, c_SW, 3'b010, 0, 0, 1, e_fetch(1, 9)), "rst_sw", 0);
    apply(v(0, c_SW, 3'b010, 0, 0, 1, e_decode(9)), "rst_sw", 1);
    apply(v(0, c_SW, 3'b010, 0, 0, 1, o(0,0,0,0,2'd0,2'd2,2'd1,2'd1,3'b000,0,0,9)), "rst_sw", 2);
    apply(v(0, c_SW, 3'b010, 0, 0, 0, o(0,1,1,0,2'd0,2'd0,2'd0,2'd0,3'b000,0,0,9)), "rst_sw", 3);
    apply(v(1, c_SW, 3'b010, 0, 0, 1, e_zero(0, 9)), "rst_sw", 4);
    apply(v(0, c_SW, 3'b010, 0, 0, 0, e_fetch(0, 0)), "rst_sw", 5);

    // Illegal opcode: sticky flag, enables held low, cleared by reset
    apply(v(0, 7'b0000000, 3'd0, 0, 0, 1, e_fetch(1, 0)), "ill", 0);
    apply(v(0, 7'b0000000, 3'd0, 0, 0, 1, e_decode(0)), "ill", 1);
    apply(v(0, 7'b0000000, 3'd0, 0, 0, 1, e_zero(0, 0)), "ill", 2);
    for (int i = 0; i < 11; i++)
      apply(v(0, 7'b0000000, 3'd0, 0, 1, 1, e_zero(1, 0)), "ill_hold", i);
    apply(v(1, 7'b0000000, 3'd0, 0, 0, 1, e_zero(1, 0)), "ill", 3);
    apply(v(0, 7'b0000000, 3'd0, 0, 0, 0, e_fetch(0, 0)), "ill", 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
